// File: rtl/patch_embed_pkg.sv
// Shared types and helpers for the patch-embedding engine.
// Optional rounding is selected by defining PATCH_EMBED_ROUND_EN (see embed_lane).
package patch_embed_pkg;

    typedef enum logic [1:0] {IDLE, CALC, EMIT, DONE} state_t;

    // Default geometry; the top exposes these as overridable parameters.
    localparam int DW_DEF      = 8;
    localparam int FRAC_DEF    = 4;
    localparam int SEQ_LEN_DEF = 15;
    localparam int EMB_DIM_DEF = 16;
    localparam int LANES_DEF   = 4;

    localparam int NTOK     = SEQ_LEN_DEF + 1;
    localparam int CALC_CYC = EMB_DIM_DEF / LANES_DEF;

    // Clamp a wide signed value into the signed range of a dw-bit word.
    function automatic int sat_dw(input int v, input int dw);
        int hi;
        int lo;
        hi = (1 <<< (dw - 1)) - 1;
        lo = -(1 <<< (dw - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/embed_lane.sv
// One embedding column: multiply, scale, saturate, bias, ReLU, positional add.
// The class-token row bypasses the projection and only adds the position term.
// Macro PATCH_EMBED_ROUND_EN: round half up before the scaling shift.
module embed_lane
    import patch_embed_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic signed [DW-1:0] x,
    input  logic signed [DW-1:0] w,
    input  logic signed [DW-1:0] b,
    input  logic signed [DW-1:0] cls,
    input  logic signed [DW-1:0] pos,
    input  logic                 is_cls,
    output logic signed [DW-1:0] tok
);

    int p;
    int s;
    int a;
    int r;
    int t;

    // Full lane datapath; all intermediates are 32-bit so nothing wraps before saturation.
    always_comb begin
        p = int'(x) * int'(w);
`ifdef PATCH_EMBED_ROUND_EN
        s = sat_dw((p + (1 <<< (FRAC - 1))) >>> FRAC, DW);
`else
        s = sat_dw(p >>> FRAC, DW);
`endif
        a = sat_dw(s + int'(b), DW);
        r = (a < 0) ? 0 : a;
        if (is_cls) t = sat_dw(int'(cls) + int'(pos), DW);
        else        t = sat_dw(r + int'(pos), DW);
        tok = DW'(t);
    end

endmodule

// File: rtl/patch_embed_engine.sv
// Patch-embedding engine: builds one token row LANES columns per cycle and
// streams rows over valid/ready, class token last. Data inputs are read live
// and must stay stable for the whole run.
// Macro PATCH_EMBED_ROUND_EN: round-half-up scaling inside each lane.
module patch_embed_engine
    import patch_embed_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int FRAC    = FRAC_DEF,
    parameter int SEQ_LEN = SEQ_LEN_DEF,
    parameter int EMB_DIM = EMB_DIM_DEF,
    parameter int LANES   = LANES_DEF,
    localparam int N_TOK  = SEQ_LEN + 1,
    localparam int RW     = $clog2(N_TOK)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [0:SEQ_LEN-1][DW-1:0]       ecg_input,
    input  logic [0:EMB_DIM-1][DW-1:0]       wt,
    input  logic [0:EMB_DIM-1][DW-1:0]       bias,
    input  logic [0:EMB_DIM-1][DW-1:0]       cls_token,
    input  logic [0:N_TOK*EMB_DIM-1][DW-1:0] pos_wt,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [0:EMB_DIM-1][DW-1:0]       out_row,
    output logic [RW-1:0]                    out_idx,
    output logic                             busy,
    output logic                             done
);

    localparam int EW = $clog2(EMB_DIM);
    localparam int PW = $clog2(N_TOK * EMB_DIM);
    localparam int SW = $clog2(SEQ_LEN);

    if (EMB_DIM % LANES != 0) begin : g_bad_lanes
        $error("EMB_DIM must be a multiple of LANES");
    end

    state_t                       state;
    logic [RW-1:0]                row;
    logic [EW-1:0]                col;
    logic [0:EMB_DIM-1][DW-1:0]   row_buf;

    logic                         is_cls;
    logic [DW-1:0]                l_x;
    logic [LANES-1:0][EW-1:0]     l_ci;
    logic [LANES-1:0][DW-1:0]     l_w, l_b, l_c, l_p, l_tok;

    assign out_row = row_buf;
    assign out_idx = row;

    // Route the current row/column group onto the lane inputs.
    always_comb begin
        is_cls = (row == RW'(SEQ_LEN));
        l_x    = is_cls ? '0 : ecg_input[SW'(row)];
        for (int l = 0; l < LANES; l++) begin
            l_ci[l] = EW'(int'(col) + l);
            l_w[l]  = wt[l_ci[l]];
            l_b[l]  = bias[l_ci[l]];
            l_c[l]  = cls_token[l_ci[l]];
            l_p[l]  = pos_wt[PW'(int'(row) * EMB_DIM + int'(col) + l)];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        embed_lane #(.DW(DW), .FRAC(FRAC)) u_lane (
            .x      (l_x),
            .w      (l_w[l]),
            .b      (l_b[l]),
            .cls    (l_c[l]),
            .pos    (l_p[l]),
            .is_cls (is_cls),
            .tok    (l_tok[l])
        );
    end

    // Control FSM with counters, row buffer and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            row_buf   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= CALC;
                    row   <= '0;
                    col   <= '0;
                    busy  <= 1'b1;
                end
                CALC: begin
                    for (int l = 0; l < LANES; l++) row_buf[l_ci[l]] <= l_tok[l];
                    if (col == EW'(EMB_DIM - LANES)) begin
                        state     <= EMIT;
                        out_valid <= 1'b1;
                    end else begin
                        col <= col + EW'(LANES);
                    end
                end
                EMIT: if (out_ready) begin
                    out_valid <= 1'b0;
                    if (is_cls) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        row   <= row + 1'b1;
                        col   <= '0;
                        state <= CALC;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_patch_embed_engine.sv
// Self-checking bench for patch_embed_engine: an arithmetic model of every
// token plus literal pins, handshake stability, latency and reset behaviour.
module tb_patch_embed_engine;
    import patch_embed_pkg::*;

    localparam int DW = 8, FRAC = 4, SEQ_LEN = 15, EMB_DIM = 16, LANES = 4;
    localparam int RW = $clog2(NTOK);

    logic clk, rst, start, out_ready, out_valid, busy, done;
    logic [0:SEQ_LEN-1][DW-1:0]      ecg;
    logic [0:EMB_DIM-1][DW-1:0]      wt, bias, cls_t;
    logic [0:NTOK*EMB_DIM-1][DW-1:0] pos;
    logic [0:EMB_DIM-1][DW-1:0]      out_row;
    logic [RW-1:0]                   out_idx;

    patch_embed_engine #(.DW(DW), .FRAC(FRAC), .SEQ_LEN(SEQ_LEN), .EMB_DIM(EMB_DIM), .LANES(LANES)) dut (
        .clk(clk), .rst(rst), .start(start), .ecg_input(ecg), .wt(wt), .bias(bias),
        .cls_token(cls_t), .pos_wt(pos), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_idx(out_idx), .busy(busy), .done(done)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int n_acc = 0, n_done = 0, exp_idx = 0;
    logic [DW-1:0] row0_v, cls_v;

    task automatic check(input string nm, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    // floor(p / 2^FRAC) by ordinary division with correction for negatives
    function automatic int floor_scale(input int p);
        int q;
        q = p / (1 << FRAC);
        if ((p % (1 << FRAC)) != 0 && p < 0) q = q - 1;
        return q;
    endfunction

    function automatic logic [DW-1:0] model_tok(input int i, input int j);
        int p, s, a, r, pv;
        pv = $signed(pos[i*EMB_DIM+j]);
        if (i == SEQ_LEN) return DW'(clamp($signed(cls_t[j]) + pv));
        p = $signed(ecg[i]) * $signed(wt[j]);
`ifdef PATCH_EMBED_ROUND_EN
        p = p + (1 << (FRAC - 1));
`endif
        s = clamp(floor_scale(p));
        a = clamp(s + $signed(bias[j]));
        r = (a < 0) ? 0 : a;
        return DW'(clamp(r + pv));
    endfunction

    // Compare process: every valid cycle against the model, plus hold stability.
    logic [0:EMB_DIM-1][DW-1:0] prev_row;
    logic [RW-1:0]              prev_idx;
    logic                       prev_hold = 0;
    always @(negedge clk) begin
        if (done) n_done++;
        if (rst || done) begin
            exp_idx = 0;
            prev_hold = 0;
        end else if (out_valid) begin
            if (prev_hold) begin
                check("hold_idx", out_idx, prev_idx);
                check("hold_row", int'(out_row == prev_row), 1);
            end
            check("idx", out_idx, exp_idx);
            if (exp_idx < NTOK)
                for (int j = 0; j < EMB_DIM; j++)
                    check($sformatf("tok[%0d][%0d]", exp_idx, j), out_row[j], model_tok(exp_idx, j));
            if (out_idx == 0) row0_v = out_row[0];
            if (out_idx == RW'(SEQ_LEN)) cls_v = out_row[0];
            prev_hold = !out_ready;
            prev_row = out_row;
            prev_idx = out_idx;
            if (out_ready) begin exp_idx++; n_acc++; end
        end else begin
            if (prev_hold) check("hold_valid", 0, 1);
            prev_hold = 0;
        end
    end

    task automatic set_uniform(input logic [DW-1:0] e, w, b, c, p);
        for (int i = 0; i < SEQ_LEN; i++) ecg[i] = e;
        for (int j = 0; j < EMB_DIM; j++) begin wt[j] = w; bias[j] = b; cls_t[j] = c; end
        for (int k = 0; k < NTOK*EMB_DIM; k++) pos[k] = p;
    endtask

    task automatic set_varied();
        for (int i = 0; i < SEQ_LEN; i++) ecg[i] = DW'(i*17 - 120);
        for (int j = 0; j < EMB_DIM; j++) begin
            wt[j] = DW'(j*11 - 90); bias[j] = DW'(j*7 - 50); cls_t[j] = DW'(j*13 - 100);
        end
        for (int k = 0; k < NTOK*EMB_DIM; k++) pos[k] = DW'((k*5) % 97 - 48);
    endtask

    // One full run. Latency = edges from the start-sampling edge to the edge
    // after which done is visible (done shows in cycle 81 counting start as 0).
    task automatic run(input int exp_lat, input bit stall, input bit spam);
        int cyc, stall_n, acc0, done0;
        bit seen;
        acc0 = n_acc; done0 = n_done; stall_n = 0; seen = 0; cyc = 0;
        @(posedge clk); #1 start = 1; out_ready = 1;
        @(posedge clk); #1 start = 0;
        while (!seen && cyc < 400) begin
            @(posedge clk); #1 cyc++;
            if (done) seen = 1;
            if (stall && out_valid && out_idx == 3 && stall_n < 10) begin
                out_ready = 0; stall_n++;
            end else out_ready = 1;
            start = spam && (cyc == 30 || cyc == 55);
        end
        check("done_seen", seen, 1);
        if (seen) check("latency", cyc, exp_lat);
        if (spam) begin
            start = 1;
            @(posedge clk); #1 start = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("busy_idle", busy, 0);
        check("tok_count", n_acc - acc0, NTOK);
        check("done_pulses", n_done - done0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, done0, k;
        rst = 1; start = 0; out_ready = 1;
        set_uniform(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_row", int'(out_row == '0), 1);
        check("rst_idx", out_idx, 0);
        @(posedge clk); #1 rst = 0;

        // 1.0 * 2.0 + 0.5 = 2.5 -> 0x28
        set_uniform(8'h10, 8'h20, 8'h08, 8'h03, 8'h00);
        run(80, 0, 0);
        check("lit_basic_row0", row0_v, 8'h28);
        check("lit_basic_cls", cls_v, 8'h03);

        // back-pressure on token 3 plus stray start pulses
        run(90, 1, 1);
        check("lit_stall_row0", row0_v, 8'h28);

        // saturation, never wrap
        set_uniform(8'h7F, 8'h7F, 8'h7F, 8'h70, 8'h20);
        run(80, 0, 0);
        check("lit_sat_row0", row0_v, 8'h7F);
        check("lit_sat_cls", cls_v, 8'h7F);

        // ReLU clamp: 1.0 * -2.0 -> 0, plus 0x05
        set_uniform(8'h10, 8'hE0, 8'h00, 8'h11, 8'h05);
        run(80, 0, 0);
        check("lit_relu_row0", row0_v, 8'h05);
        check("lit_relu_cls", cls_v, 8'h16);

        // 0x01 * 0x08 = 8/16: truncates to 0, rounds to 1
        set_uniform(8'h01, 8'h08, 8'h00, 8'h00, 8'h00);
        run(80, 0, 0);
`ifdef PATCH_EMBED_ROUND_EN
        check("lit_round_row0", row0_v, 8'h01);
`else
        check("lit_round_row0", row0_v, 8'h00);
`endif

        // per-column/per-row distinct data exercises lane and index routing
        set_varied();
        run(80, 0, 0);

        // reset during CALC of token 7
        acc0 = n_acc; done0 = n_done; k = 0;
        @(posedge clk); #1 start = 1; out_ready = 1;
        @(posedge clk); #1 start = 0;
        while (!(out_valid && out_idx == 6) && k < 200) begin
            @(posedge clk); #1 k++;
        end
        check("reach_tok6", int'(k < 200), 1);
        @(posedge clk); #1 rst = 1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_row", int'(out_row == '0), 1);
        check("mid_rst_idx", out_idx, 0);
        @(posedge clk); #1 rst = 0;
        check("mid_rst_acc", n_acc - acc0, 7);
        check("mid_rst_nodone", n_done - done0, 0);
        run(80, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
